// File: rtl/mac_accumulator.sv
// Purpose: sums a window of signed products with saturation, then requantises the sum (shift, optional ReLU, clamp).
// Latency: the result is registered on the edge that accepts the in_last beat, so out_valid is high right after that edge.
// Backpressure: while a result is held unaccepted, in_ready is low and the accumulator is frozen, so no beat is lost.
module mac_accumulator #(
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 8,
  parameter int SHIFT   = 0,
  parameter int RELU_EN = 0,
  parameter int CNT_W   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);

  // Saturation limits at the one-bit-wider sum width.
  localparam logic signed [ACC_W:0]   SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  // Output clamp limits expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_ovf_q, out_ovf_d;

  logic                    accept;
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W-1:0] sum_sat;
  logic                    clamped;
  logic [CNT_W-1:0]        cnt_inc;
  logic signed [ACC_W-1:0] shifted;
  logic [OUT_W-1:0]        requant;

  // Ready depends only on reset and the output slot, never on in_valid.
  assign in_ready = rst_n & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // Saturating add, saturating term count and requantisation of the running sum.
  always_comb begin
    sum_wide = $signed({acc_q[ACC_W-1], acc_q})
             + $signed({{(ACC_W+1-PROD_W){in_prod[PROD_W-1]}}, in_prod});
    clamped  = 1'b0;
    sum_sat  = sum_wide[ACC_W-1:0];
    if (sum_wide > SUM_MAX) begin
      sum_sat = SUM_MAX[ACC_W-1:0];
      clamped = 1'b1;
    end else if (sum_wide < SUM_MIN) begin
      sum_sat = SUM_MIN[ACC_W-1:0];
      clamped = 1'b1;
    end

    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    shifted = sum_sat >>> SHIFT;
    if (RELU_EN != 0 && shifted < 0) begin
      shifted = '0;
    end
    if (shifted > OUT_MAX) begin
      requant = OUT_MAX[OUT_W-1:0];
    end else if (shifted < OUT_MIN) begin
      requant = OUT_MIN[OUT_W-1:0];
    end else begin
      requant = shifted[OUT_W-1:0];
    end
  end

  // Next-state: update the window on each accepted beat, load the result on the last one.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_acc_d   = out_acc_q;
    out_cnt_d   = out_cnt_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (in_last) begin
        // A new result overrides the clear above, giving back-to-back windows.
        out_valid_d = 1'b1;
        out_data_d  = requant;
        out_acc_d   = sum_sat;
        out_cnt_d   = cnt_inc;
        out_ovf_d   = ovf_q | clamped;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = sum_sat;
        cnt_d = cnt_inc;
        ovf_d = ovf_q | clamped;
      end
    end
  end

  // State registers with synchronous active-low reset; a partial window is discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_acc_q   <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_acc_q   <= out_acc_d;
      out_cnt_q   <= out_cnt_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_acc   = out_acc_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: default instance (SHIFT=0, no ReLU) and a ReLU/SHIFT=4 instance.
// Inputs change 1ns after the rising edge; outputs are checked 1ns after the edge.
// Expected values are hand-computed constants in each step.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_ovf;
  logic [15:0] a_in_prod;
  logic [7:0]  a_out_data;
  logic [23:0] a_out_acc;
  logic [8:0]  a_out_cnt;

  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
  logic [15:0] b_in_prod;
  logic [7:0]  b_out_data;
  logic [23:0] b_out_acc;
  logic [8:0]  b_out_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mac_accumulator dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_prod(a_in_prod), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_acc(a_out_acc), .out_cnt(a_out_cnt), .out_ovf(a_out_ovf)
  );

  mac_accumulator #(.SHIFT(4), .RELU_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_acc(b_out_acc), .out_cnt(b_out_cnt), .out_ovf(b_out_ovf)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int p, input bit l);
    int n = 0;
    a_in_valid = 1'b1;
    a_in_prod  = p[15:0];
    a_in_last  = l;
    while (!a_in_ready && n < 20) begin
      step();
      n++;
    end
    if (!a_in_ready) chk("a_in_ready_timeout", int'(a_in_ready), 1);
    step();
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic send_b(input int p, input bit l);
    int n = 0;
    b_in_valid = 1'b1;
    b_in_prod  = p[15:0];
    b_in_last  = l;
    while (!b_in_ready && n < 20) begin
      step();
      n++;
    end
    if (!b_in_ready) chk("b_in_ready_timeout", int'(b_in_ready), 1);
    step();
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_prod = '0; a_in_last = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_prod = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", int'(a_out_valid), 0);
    chk("rst_in_ready", int'(a_in_ready), 0);
    chk("rst_out_acc", int'($signed(a_out_acc)), 0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", int'(a_in_ready), 1);
    step();

    // 1: 100 - 20 + 5 = 85
    send_a(100, 1'b0);
    send_a(-20, 1'b0);
    chk("t1_no_early_valid", int'(a_out_valid), 0);
    send_a(5, 1'b1);
    chk("t1_valid", int'(a_out_valid), 1);
    chk("t1_acc", int'($signed(a_out_acc)), 85);
    chk("t1_data", int'($signed(a_out_data)), 85);
    chk("t1_cnt", int'(a_out_cnt), 3);
    chk("t1_ovf", int'(a_out_ovf), 0);
    step();
    chk("t1_valid_drop", int'(a_out_valid), 0);

    // 2: single beat -300 clamps output to -128
    send_a(-300, 1'b1);
    chk("t2_valid", int'(a_out_valid), 1);
    chk("t2_acc", int'($signed(a_out_acc)), -300);
    chk("t2_data", int'($signed(a_out_data)), -128);
    chk("t2_cnt", int'(a_out_cnt), 1);
    step();

    // 3: 300 x 32767 saturates the accumulator at 2^23-1
    for (int i = 0; i < 300; i++) begin
      send_a(32767, i == 299);
    end
    chk("t3_valid", int'(a_out_valid), 1);
    chk("t3_acc", int'($signed(a_out_acc)), 8388607);
    chk("t3_ovf", int'(a_out_ovf), 1);
    chk("t3_data", int'($signed(a_out_data)), 127);
    chk("t3_cnt", int'(a_out_cnt), 300);
    step();

    // 4: backpressure holds window 1 while window 2's last beat waits
    a_out_ready = 1'b0;
    send_a(40, 1'b1);
    chk("t4_w1_acc", int'($signed(a_out_acc)), 40);
    a_in_valid = 1'b1;
    a_in_prod  = 16'd11;
    a_in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_in_ready_low", int'(a_in_ready), 0);
      chk("t4_hold_valid", int'(a_out_valid), 1);
      chk("t4_hold_acc", int'($signed(a_out_acc)), 40);
      step();
    end
    a_out_ready = 1'b1;
    #1;
    chk("t4_in_ready_high", int'(a_in_ready), 1);
    step();
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
    chk("t4_w2_valid", int'(a_out_valid), 1);
    chk("t4_w2_acc", int'($signed(a_out_acc)), 11);
    chk("t4_w2_cnt", int'(a_out_cnt), 1);
    step();
    chk("t4_valid_drop", int'(a_out_valid), 0);

    // 5: ReLU with SHIFT=4
    send_b(-100, 1'b0);
    send_b(-60, 1'b1);
    chk("t5_neg_acc", int'($signed(b_out_acc)), -160);
    chk("t5_neg_data", int'($signed(b_out_data)), 0);
    step();
    send_b(400, 1'b0);
    send_b(80, 1'b1);
    chk("t5_pos_acc", int'($signed(b_out_acc)), 480);
    chk("t5_pos_data", int'($signed(b_out_data)), 30);
    chk("t5_pos_cnt", int'(b_out_cnt), 2);
    step();

    // 6: reset discards a partial window
    send_a(50, 1'b0);
    send_a(60, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_in_ready_rst", int'(a_in_ready), 0);
    step();
    chk("t6_rst_acc", int'($signed(a_out_acc)), 0);
    chk("t6_rst_cnt", int'(a_out_cnt), 0);
    chk("t6_rst_valid", int'(a_out_valid), 0);
    rst_n = 1'b1;
    send_a(7, 1'b1);
    chk("t6_acc", int'($signed(a_out_acc)), 7);
    chk("t6_cnt", int'(a_out_cnt), 1);
    chk("t6_valid", int'(a_out_valid), 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
